// File: rtl/mem_pkg.sv
// Shared definitions for the external memory responder.
//   state_t : FSM encodings (IDLE, WAIT, ACK)
//   op_t    : latched operation (OP_RD, OP_WR)
//   DEFAULT_WORD_SIZE : default data width in bits
package mem_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/ext_mem_port_if.sv
// Request/response bus between the cache miss controller (master) and the
// external memory responder (slave).
//   ext_addr : byte address          ext_re / ext_wr : level requests, held until ack
//   wr_data  : write data            rd_data         : read data, valid with ext_ack
//   ext_ack  : one-cycle completion  busy            : responder in WAIT or ACK
interface ext_mem_port_if
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
);
    logic [31:0]          ext_addr;
    logic                 ext_re;
    logic                 ext_wr;
    logic [WORD_SIZE-1:0] wr_data;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 ext_ack;
    logic                 busy;

    modport master (
        output ext_addr, ext_re, ext_wr, wr_data,
        input  rd_data, ext_ack, busy
    );

    modport slave (
        input  ext_addr, ext_re, ext_wr, wr_data,
        output rd_data, ext_ack, busy
    );
endinterface

// File: rtl/word_ram.sv
// Single-port synchronous word array with registered read, no reset.
//   clk  : clock            we  : write enable
//   idx  : word index       din : write data
//   dout : read data, registered (read-before-write on a write cycle)
module word_ram #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout
);
    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
        dout <= mem[idx];
    end
endmodule

// File: rtl/ext_mem_port.sv
// Word-wide external memory responder for the cache miss controller.
// Serves ext_re / ext_wr after LATENCY wait cycles and returns a one-cycle
// ext_ack per word, followed by a mandatory idle cycle.
//   clk, ctr_rst : clock and asynchronous active-high reset
//   bus          : ext_mem_port_if slave side (request in, rd_data/ext_ack/busy out)
module ext_mem_port
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input logic           clk,
    input logic           ctr_rst,
    ext_mem_port_if.slave bus
);
    localparam int unsigned CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [ADDR_BITS-1:0] idx;
    op_t                  op;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 ext_ack;
    logic                 busy;

    logic [ADDR_BITS-1:0] addr_idx;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 ram_we;
    logic [WORD_SIZE-1:0] ram_dout;
    logic                 req_held;
    logic                 unused_addr;

    assign unused_addr = ^{bus.ext_addr[31:ADDR_BITS+2], bus.ext_addr[1:0]};

    always_comb begin
        addr_idx = bus.ext_addr[ADDR_BITS+1:2];
        req_held = (op == OP_WR) ? bus.ext_wr : bus.ext_re;
        // The write lands on the edge that enters ACK, unless the request dropped.
        ram_we   = (state == WAIT) && req_held && (cnt == '0) && (op == OP_WR);
        // Index the array from the bus while idle so the read data is already
        // settled by the first WAIT edge, which keeps LATENCY=1 correct.
        ram_idx  = (state == IDLE) ? addr_idx : idx;
    end

    word_ram #(
        .WIDTH     (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (ram_idx),
        .din  (wdata),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or posedge ctr_rst) begin
        if (ctr_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            op      <= OP_RD;
            wdata   <= '0;
            rd_data <= '0;
            ext_ack <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ext_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ext_wr || bus.ext_re) begin
                        idx   <= addr_idx;
                        op    <= bus.ext_wr ? OP_WR : OP_RD;
                        wdata <= bus.wr_data;
                        cnt   <= LAT_M1;
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state   <= ACK;
                        ext_ack <= 1'b1;
                        if (op == OP_RD) begin
                            rd_data <= ram_dout;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.ext_ack = ext_ack;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_ext_mem_port.sv
module tb_ext_mem_port;
    localparam int unsigned WS  = 32;
    localparam int unsigned AB  = 10;
    localparam int unsigned LAT = 2;

    logic clk;
    logic ctr_rst;
    int   n_tests;
    int   n_fail;

    ext_mem_port_if #(.WORD_SIZE(WS)) bus ();

    ext_mem_port #(
        .WORD_SIZE (WS),
        .ADDR_BITS (AB),
        .LATENCY   (LAT)
    ) dut (
        .clk     (clk),
        .ctr_rst (ctr_rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory: word index -> value, only for words the bench has written.
    logic [31:0] ref_mem [int];

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % (2 ** AB));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transfer as the miss controller would do it: hold the request
    // until ack, then release it. lat = edges after the capture edge until ack.
    task automatic xfer(input logic [31:0] addr, input logic re, input logic wr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
        @(negedge clk);
        bus.ext_addr = addr;
        bus.ext_re   = re;
        bus.ext_wr   = wr;
        bus.wr_data  = wd;
        lat = -1;
        rd  = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.ext_ack) begin
                lat = n - 1;
                rd  = bus.rd_data;
                break;
            end
        end
        bus.ext_re = 1'b0;
        bus.ext_wr = 1'b0;
        if (lat >= 0) begin
            @(posedge clk);
            #1;
            check("ack_one_cycle", {31'b0, bus.ext_ack}, 32'h0);
        end
    endtask

    // Transfer checked against the reference model.
    task automatic model_xfer(input string name, input logic [31:0] addr, input logic re,
                              input logic wr, input logic [31:0] wd);
        int          lat;
        logic [31:0] rd;
        int          k;
        xfer(addr, re, wr, wd, lat, rd);
        check({name, "_latency"}, lat, LAT);
        k = widx(addr);
        if (wr) begin
            ref_mem[k] = wd;
        end else if (ref_mem.exists(k)) begin
            check({name, "_rdata"}, rd, ref_mem[k]);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic        wr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        int          lat;
        logic [31:0] rd;
        logic [31:0] addr;
        int          k;
        int          last;
        bit          saw_ack;

        n_tests = 0;
        n_fail  = 0;
        bus.ext_addr = '0;
        bus.ext_re   = 1'b0;
        bus.ext_wr   = 1'b0;
        bus.wr_data  = '0;
        ctr_rst      = 1'b1;

        vecs[0] = '{32'h40,   1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{32'h40,   1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2] = '{32'h10,   1'b1, 1'b1, 32'h5,        1'b0, 32'h0};
        vecs[3] = '{32'h10,   1'b1, 1'b0, 32'h0,        1'b1, 32'h5};
        vecs[4] = '{32'h0,    1'b0, 1'b1, 32'hCAFE0001, 1'b0, 32'h0};
        vecs[5] = '{32'h1003, 1'b1, 1'b0, 32'h0,        1'b1, 32'hCAFE0001};
        vecs[6] = '{32'h1000, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0};
        vecs[7] = '{32'h0,    1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678};
        vecs[8] = '{32'h44,   1'b0, 1'b1, 32'h33,       1'b0, 32'h0};
        vecs[9] = '{32'h47,   1'b1, 1'b0, 32'h0,        1'b1, 32'h33};

        #1;
        check("rst_ack", {31'b0, bus.ext_ack}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_rd_data", bus.rd_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        ctr_rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].addr, vecs[i].re, vecs[i].wr, vecs[i].wdata, lat, rd);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end
            if (vecs[i].wr) begin
                ref_mem[widx(vecs[i].addr)] = vecs[i].wdata;
            end
        end

        // Streaming 16-word line read from 0x80, advancing on each ack.
        for (int i = 0; i < 16; i++) begin
            model_xfer("preload", 32'h80 + 32'(4 * i), 1'b0, 1'b1, 32'(i) * 32'h11111111);
        end
        @(negedge clk);
        addr         = 32'h80;
        bus.ext_addr = addr;
        bus.ext_re   = 1'b1;
        k    = 0;
        last = -1;
        for (int cyc = 0; cyc < 200 && k < 16; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.ext_ack) begin
                check($sformatf("stream%0d_data", k), bus.rd_data, 32'(k) * 32'h11111111);
                if (last >= 0) begin
                    check($sformatf("stream%0d_period", k), cyc - last, LAT + 2);
                end
                last = cyc;
                k++;
                addr         = addr + 32'd4;
                bus.ext_addr = addr;
            end
        end
        bus.ext_re = 1'b0;
        check("stream_ack_count", k, 16);
        @(posedge clk);

        // Read dropped during WAIT: no ack, back to idle.
        @(negedge clk);
        bus.ext_addr = 32'h40;
        bus.ext_re   = 1'b1;
        @(posedge clk);
        #1;
        check("drop_busy_in_wait", {31'b0, bus.busy}, 32'h1);
        @(negedge clk);
        bus.ext_re = 1'b0;
        @(posedge clk);
        #1;
        check("drop_busy_idle", {31'b0, bus.busy}, 32'h0);
        saw_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.ext_ack) saw_ack = 1'b1;
            @(posedge clk);
            #1;
        end
        check("drop_no_ack", {31'b0, saw_ack}, 32'h0);
        model_xfer("after_drop", 32'h10, 1'b1, 1'b0, 32'h0);

        // Write dropped just before the edge that would enter ACK: no write.
        @(negedge clk);
        bus.ext_addr = 32'h44;
        bus.ext_wr   = 1'b1;
        bus.wr_data  = 32'h77;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        bus.ext_wr = 1'b0;
        @(posedge clk);
        #1;
        check("late_drop_no_ack", {31'b0, bus.ext_ack}, 32'h0);
        check("late_drop_busy", {31'b0, bus.busy}, 32'h0);
        model_xfer("late_drop_old", 32'h44, 1'b1, 1'b0, 32'h0);

        // Asynchronous reset in WAIT of a write: outputs clear, array untouched.
        model_xfer("rst_pre_wr", 32'h20, 1'b0, 1'b1, 32'h1);
        model_xfer("rst_pre_rd", 32'h20, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        bus.ext_addr = 32'h20;
        bus.ext_wr   = 1'b1;
        bus.wr_data  = 32'hBAD;
        @(posedge clk);
        #3;
        check("rst_mid_busy_before", {31'b0, bus.busy}, 32'h1);
        ctr_rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'b0, bus.ext_ack}, 32'h0);
        check("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_mid_rd_data", bus.rd_data, 32'h0);
        @(negedge clk);
        bus.ext_wr = 1'b0;
        ctr_rst    = 1'b0;
        model_xfer("rst_post_rd", 32'h20, 1'b1, 1'b0, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic        rre;
            logic        rwr;
            int          sel;
            ra  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
            sel = $urandom_range(0, 3);
            rwr = (sel == 0) || (sel == 3);
            rre = (sel != 0);
            model_xfer($sformatf("rand%0d", i), ra, rre, rwr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
